// File: rtl/itl_frame_ctrl.sv
// Block framing controller in front of the dual-port interleaver RAM: loads K bits, sweeps reads, emits (sys, itl) pairs.
// Optional block counter output blk_cnt is enabled by defining ITL_FRAME_CNT_EN.
module itl_frame_ctrl #(
  parameter int A_WIDTH = 16
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [A_WIDTH-1:0] cfg_len,
  input  logic [A_WIDTH-1:0] cfg_jump,
  input  logic               s_valid,
  input  logic               s_data,
  output logic               s_ready,
  output logic               ram_wdata,
  output logic [A_WIDTH-1:0] ram_waddr,
  output logic               ram_wen,
  output logic [A_WIDTH-1:0] ram_id_jump,
  input  logic               ram_rdata,
  input  logic               ram_rdata_itl,
  output logic               m_valid,
  output logic               m_sys,
  output logic               m_itl,
  output logic               m_last,
  output logic               err
`ifdef ITL_FRAME_CNT_EN
  ,
  output logic [A_WIDTH-1:0] blk_cnt
`endif
);

  localparam logic [A_WIDTH-1:0] ZERO = {A_WIDTH{1'b0}};
  localparam logic [A_WIDTH-1:0] ONE  = {{(A_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  state_t             r_state;
  logic [A_WIDTH-1:0] r_len;
  logic [A_WIDTH-1:0] r_jump;
  logic [A_WIDTH-1:0] r_wcnt;
  logic [A_WIDTH-1:0] r_rcnt;
  logic               r_s_ready;
  logic               r_wen;
  logic [A_WIDTH-1:0] r_waddr;
  logic               r_wdata;
  logic               r_err;
  logic [3:0]         r_rd_v;
  logic [3:0]         r_rd_last;
  logic               r_itl_hold;
  logic               r_m_valid;
  logic               r_m_sys;
  logic               r_m_itl;
  logic               r_m_last;

  state_t             w_state_nxt;
  logic               w_hs;
  logic               w_latch;
  logic               w_s_ready_nxt;
  logic               w_wen_nxt;
  logic [A_WIDTH-1:0] w_waddr_nxt;
  logic               w_wdata_nxt;
  logic [A_WIDTH-1:0] w_wcnt_nxt;
  logic [A_WIDTH-1:0] w_wcnt_inc;
  logic [A_WIDTH-1:0] w_rcnt_nxt;
  logic               w_err_nxt;
  logic               w_rd_issue;
  logic               w_rd_last;

  assign w_hs       = s_valid && r_s_ready;
  assign w_wcnt_inc = r_wcnt + ONE;

  // FSM state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and next values for the registered outputs
  always_comb begin
    w_state_nxt   = r_state;
    w_latch       = 1'b0;
    w_s_ready_nxt = r_s_ready;
    w_wen_nxt     = 1'b0;
    w_waddr_nxt   = r_waddr;
    w_wdata_nxt   = r_wdata;
    w_wcnt_nxt    = r_wcnt;
    w_rcnt_nxt    = r_rcnt;
    w_err_nxt     = 1'b0;
    w_rd_issue    = 1'b0;
    w_rd_last     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_s_ready_nxt = 1'b1;
        if (w_hs) begin
          w_latch = 1'b1;
          if (cfg_len == ZERO) begin
            // zero-length block: drop the bit and flag it
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_wen_nxt   = 1'b1;
            w_waddr_nxt = ZERO;
            w_wdata_nxt = s_data;
            w_wcnt_nxt  = ONE;
            w_rcnt_nxt  = ZERO;
            if (cfg_len == ONE) begin
              w_state_nxt   = ST_DRAIN;
              w_s_ready_nxt = 1'b0;
            end else begin
              w_state_nxt = ST_LOAD;
            end
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (w_hs) begin
          w_wen_nxt   = 1'b1;
          w_waddr_nxt = r_wcnt;
          w_wdata_nxt = s_data;
          w_wcnt_nxt  = w_wcnt_inc;
          if (w_wcnt_inc == r_len) begin
            w_state_nxt   = ST_DRAIN;
            w_s_ready_nxt = 1'b0;
          end else begin
            w_state_nxt = ST_LOAD;
          end
        end else begin
          w_wen_nxt = 1'b0;
        end
      end
      ST_DRAIN: begin
        w_s_ready_nxt = 1'b0;
        w_waddr_nxt   = r_rcnt;
        w_rd_issue    = 1'b1;
        w_rd_last     = (r_rcnt == (r_len - ONE));
        if (w_rd_last) begin
          w_state_nxt = ST_FLUSH;
          w_rcnt_nxt  = ZERO;
        end else begin
          w_rcnt_nxt = r_rcnt + ONE;
        end
      end
      ST_FLUSH: begin
        // the last pair leaving the read pipeline reopens the input
        if (r_m_last) begin
          w_state_nxt   = ST_IDLE;
          w_s_ready_nxt = 1'b1;
        end else begin
          w_state_nxt   = ST_FLUSH;
          w_s_ready_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_s_ready_nxt = 1'b0;
      end
    endcase
  end

  // Control registers: configuration latch, counters and RAM write/address port
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_len     <= ZERO;
      r_jump    <= ZERO;
      r_wcnt    <= ZERO;
      r_rcnt    <= ZERO;
      r_s_ready <= 1'b0;
      r_wen     <= 1'b0;
      r_waddr   <= ZERO;
      r_wdata   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_latch) begin
        r_len  <= cfg_len;
        r_jump <= cfg_jump;
      end
      r_wcnt    <= w_wcnt_nxt;
      r_rcnt    <= w_rcnt_nxt;
      r_s_ready <= w_s_ready_nxt;
      r_wen     <= w_wen_nxt;
      r_waddr   <= w_waddr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // Read pipeline: itl data lands 2 cycles after the address, sys data 3, pair leaves at 4
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_rd_v     <= 4'b0000;
      r_rd_last  <= 4'b0000;
      r_itl_hold <= 1'b0;
      r_m_valid  <= 1'b0;
      r_m_sys    <= 1'b0;
      r_m_itl    <= 1'b0;
      r_m_last   <= 1'b0;
    end else begin
      r_rd_v     <= {r_rd_v[2:0], w_rd_issue};
      r_rd_last  <= {r_rd_last[2:0], w_rd_last};
      r_itl_hold <= r_rd_v[2] ? ram_rdata_itl : 1'b0;
      r_m_valid  <= r_rd_v[3];
      r_m_sys    <= r_rd_v[3] ? ram_rdata : 1'b0;
      r_m_itl    <= r_rd_v[3] ? r_itl_hold : 1'b0;
      r_m_last   <= r_rd_v[3] & r_rd_last[3];
    end
  end

`ifdef ITL_FRAME_CNT_EN
  logic [A_WIDTH-1:0] r_blk_cnt;

  // Completed-block counter, stepped the cycle after each m_last
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_blk_cnt <= ZERO;
    end else if (r_m_last) begin
      r_blk_cnt <= r_blk_cnt + ONE;
    end
  end

  assign blk_cnt = r_blk_cnt;
`endif

  assign s_ready     = r_s_ready;
  assign ram_wdata   = r_wdata;
  assign ram_waddr   = r_waddr;
  assign ram_wen     = r_wen;
  assign ram_id_jump = r_jump;
  assign m_valid     = r_m_valid;
  assign m_sys       = r_m_sys;
  assign m_itl       = r_m_itl;
  assign m_last      = r_m_last;
  assign err         = r_err;

endmodule

// File: doc/itl_frame_ctrl.md
Name: itl_frame_ctrl

Overview:
- Block-level controller directly upstream of the dual-port interleaver RAM/ROM stage.
- Accepts a serial bitstream with a valid/ready handshake and writes one block of K bits into the RAM.
- Then sweeps read addresses 0..K-1 and collects the RAM's systematic and interleaved read data, realigned to a common cycle.
- Emits bit pairs (systematic, interleaved) with a last-bit marker to the encoder/decoder stage downstream.

Parameters:
- A_WIDTH, 16, RAM address width; also the width of cfg_len, cfg_jump and all counters.

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- cfg_len  in  A_WIDTH  block length K; sampled in IDLE on the first accepted bit
- cfg_jump  in  A_WIDTH  interleaver-table offset; sampled with cfg_len
- s_valid  in  1  input bit valid
- s_data  in  1  input bit
- s_ready  out  1  block can accept a bit
- ram_wdata  out  1  RAM write data
- ram_waddr  out  A_WIDTH  RAM write address during LOAD; read address during DRAIN
- ram_wen  out  1  RAM write enable
- ram_id_jump  out  A_WIDTH  table offset to RAM (latched cfg_jump)
- ram_rdata  in  1  RAM systematic read; valid 3 cycles after ram_waddr is presented
- ram_rdata_itl  in  1  RAM interleaved read; valid 2 cycles after ram_waddr is presented
- m_valid  out  1  output pair valid
- m_sys  out  1  systematic bit
- m_itl  out  1  interleaved bit
- m_last  out  1  marks bit K-1 of the block
- err  out  1  one-cycle pulse: zero-length block rejected

Behaviour:
- Reset is asynchronous and active-low, with one clock: clk, n_rst.
- Reset values: all outputs 0, state IDLE, counters 0, ram_id_jump 0. s_ready is 0 during reset and goes to 1 on the first clock after release. RAM contents are not cleared.
- All outputs are registered. No backpressure on the m_* side.
- States:
  - IDLE: s_ready=1. On s_valid&&s_ready, latch K=cfg_len and jump=cfg_jump.
    - If K==0: pulse err next cycle, drop the bit, stay IDLE.
    - Otherwise the bit is the first write (address 0); go to LOAD with wcnt=1.
  - LOAD: each handshake writes one bit. Next cycle ram_wen=1, ram_waddr=wcnt-before-increment, ram_wdata=s_data. No handshake means ram_wen=0 that cycle.
    - When the K-th bit is accepted, s_ready is 0 from the next cycle and the state moves to DRAIN.
    - K==1 goes from IDLE straight to DRAIN.
  - DRAIN: ram_wen=0. ram_waddr steps 0,1,…,K-1, one per cycle. The first read address appears the cycle after the last write. After address K-1, go to FLUSH.
  - FLUSH: wait until the read pipeline is empty (last m_valid asserted), then IDLE. s_ready=1 the cycle after m_last.
- Alignment:
  - For an address presented in cycle c, capture ram_rdata_itl at c+2 into a holding register.
  - Capture ram_rdata at c+3.
  - m_valid/m_sys/m_itl are registered at c+4. Fixed latency is 4 cycles from read address to output.
  - m_valid is high for exactly K consecutive cycles. m_last is high with the K-th pair only.
- ram_id_jump is held at the latched jump from acquisition until the next block is latched.
- cfg_len/cfg_jump changes after latching are ignored until the next IDLE acquisition.
- Counters are A_WIDTH wide. K=2^A_WIDTH-1 is the maximum; no wrap within a block.
- Reset mid-block: immediate return to IDLE; m_valid, ram_wen and m_last deassert asynchronously; the partial block is discarded.
- s_valid while s_ready=0 is ignored; the bit is not consumed.

Optional Feature:
- Macro: ITL_FRAME_CNT_EN.
- Defined: adds output blk_cnt [A_WIDTH-1:0], reset 0. It increments the cycle after each m_last and wraps 2^A_WIDTH-1→0. Rejected (err) blocks are not counted.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- K=8, jump=0, s_valid always high, s_data=10110010: ram_wen high 8 cycles with addresses 0..7. Read addresses 0..7 follow the cycle after the last write. m_valid is high 8 cycles starting 4 cycles after read address 0. m_sys=10110010. m_last is on the 8th pair.
- K=8, identity ROM behind the RAM model: m_itl equals the systematic data delayed correctly, m_itl==m_sys every cycle. This checks the 2-vs-3 cycle realignment.
- K=5 with s_valid toggling 1,0,1,0…: writes occur only on handshake cycles, addresses stay contiguous 0..4, and DRAIN starts only after the 5th bit.
- cfg_len=0 with s_valid=1: err pulses for 1 cycle, ram_wen stays 0, state stays IDLE. A following K=1 block outputs one pair with m_valid=m_last=1.
- n_rst asserted in the 3rd DRAIN cycle of a K=16 block: m_valid=0 immediately, s_ready=1 after release. A new K=4 block then runs normally.
- ITL_FRAME_CNT_EN defined, three back-to-back K=4 blocks: blk_cnt reads 1, 2, 3 after each m_last.
